// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory and IF/ID handshake bundle for fetch_unit
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        ID_valid;
  logic        ID_ready;
  logic [31:0] ID_instr;
  logic [63:0] ID_pc;

  // fetch_unit side: issues requests, consumes responses, presents the queue head
  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_resp_valid,
    input  imem_resp_data,
    output ID_valid,
    input  ID_ready,
    output ID_instr,
    output ID_pc
  );

  // memory / decode side
  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_resp_valid,
    output imem_resp_data,
    input  ID_valid,
    output ID_ready,
    input  ID_instr,
    input  ID_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV64I fetch stage: imem requests, in-order fetch queue, redirect flush
module fetch_unit #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] PC,
  output logic [63:0] PCNext,
  input  logic        redirect,
  input  logic [63:0] redirect_target,
  fetch_unit_if.master bus
);

  // The PC side FIFO also holds entries for responses that will be dropped after
  // a redirect, so it is twice MAX_OUT deep; issue stalls if it ever fills, which
  // only happens with back-to-back redirects against a slow memory.
  localparam int SIDE_DEPTH = 2 * MAX_OUT;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = (SIDE_DEPTH > 1) ? $clog2(SIDE_DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + SIDE_DEPTH + 1) + 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
  localparam logic [CW-1:0] SIDE_C    = CW'(SIDE_DEPTH);
  localparam logic [SW-1:0] SIDE_LAST = SW'(SIDE_DEPTH - 1);

  // fetch queue storage
  logic [31:0] q_instr [DEPTH];
  logic [63:0] q_pc    [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] occ_q, occ_d;

  // request tracking
  logic [63:0]   sf_pc [SIDE_DEPTH];
  logic [SW-1:0] sf_rd_q, sf_rd_d, sf_wr_q, sf_wr_d;
  logic [CW-1:0] sf_cnt_q, sf_cnt_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;

  logic req_valid, fire;
  logic resp_ok, resp_drop, resp_live, push, pop;

  function automatic logic [SW-1:0] sf_next(input logic [SW-1:0] p);
    return (p == SIDE_LAST) ? '0 : p + 1'b1;
  endfunction

  // handshake decode: which request fires, which response is kept, which head pops
  always_comb begin
    req_valid = rst && !redirect
                && ((occ_q + out_q) < DEPTH_C)
                && (out_q < MAX_OUT_C)
                && (sf_cnt_q < SIDE_C);
    fire      = req_valid && bus.imem_req_ready;
    // a response with nothing in flight is a protocol error and is ignored
    resp_ok   = bus.imem_resp_valid && ((out_q != '0) || (drop_q != '0));
    resp_drop = resp_ok && (drop_q != '0);
    resp_live = resp_ok && (drop_q == '0);
    push      = resp_live && !redirect;
    pop       = (occ_q != '0) && bus.ID_ready;
  end

  // outward signals: request, queue head and next PC
  always_comb begin
    bus.imem_req_valid = req_valid;
    bus.imem_req_addr  = PC;
    bus.ID_valid       = (occ_q != '0);
    bus.ID_instr       = q_instr[head_q];
    bus.ID_pc          = q_pc[head_q];
    if (redirect) begin
      PCNext = redirect_target;
    end else if (fire) begin
      PCNext = PC + 64'd4;
    end else begin
      PCNext = PC;
    end
  end

  // next-state for pointers and counters; redirect flushes the queue after any pop
  always_comb begin
    head_d   = head_q + PW'(pop);
    tail_d   = tail_q + PW'(push);
    occ_d    = occ_q + CW'(push) - CW'(pop);
    out_d    = out_q + CW'(fire) - CW'(resp_live);
    drop_d   = drop_q - CW'(resp_drop);
    sf_wr_d  = fire ? sf_next(sf_wr_q) : sf_wr_q;
    sf_rd_d  = resp_ok ? sf_next(sf_rd_q) : sf_rd_q;
    sf_cnt_d = sf_cnt_q + CW'(fire) - CW'(resp_ok);
    if (redirect) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
      out_d  = '0;
      // everything still in flight becomes stale, except a response landing now
      drop_d = drop_q + out_q - CW'(resp_ok);
    end
  end

  // control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      occ_q    <= '0;
      out_q    <= '0;
      drop_q   <= '0;
      sf_rd_q  <= '0;
      sf_wr_q  <= '0;
      sf_cnt_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      occ_q    <= occ_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      sf_rd_q  <= sf_rd_d;
      sf_wr_q  <= sf_wr_d;
      sf_cnt_q <= sf_cnt_d;
    end
  end

  // data storage: request PCs on fire, {instr, pc} on accepted response
  always_ff @(posedge clk) begin
    if (fire) begin
      sf_pc[sf_wr_q] <= PC;
    end
    if (push) begin
      q_instr[tail_q] <= bus.imem_resp_data;
      q_pc[tail_q]    <= sf_pc[sf_rd_q];
    end
  end

  // responses must only arrive for requests still in flight
  resp_expected_a : assert property (
    @(posedge clk) disable iff (!rst)
      bus.imem_resp_valid |-> ((out_q != '0) || (drop_q != '0))
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] PC;
  logic [63:0] PCNext;
  logic        redirect;
  logic [63:0] redirect_target;

  fetch_unit_if bus ();

  fetch_unit #(.DEPTH(4), .MAX_OUT(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .PC              (PC),
    .PCNext          (PCNext),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .bus             (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id_ready;
    logic        req_valid;
    logic [63:0] pcnext;
    logic        id_valid;
    logic [63:0] id_pc;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] pend [$];
  logic        s_req_valid, s_id_valid;
  logic [63:0] s_pcnext, s_id_pc;
  logic [31:0] s_id_instr;
  vec_t        tbl [21];

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic r, input logic rv, input logic [63:0] pn,
                              input logic iv, input logic [63:0] ipc);
    vec_t v;
    v.id_ready = r; v.req_valid = rv; v.pcnext = pn; v.id_valid = iv; v.id_pc = ipc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // one clock: drive at negedge, sample 1ns later, then act as PC register and memory
  task automatic cyc(input logic rd, input logic [63:0] tgt, input logic idr,
                     input logic rqr, input logic ren);
    logic resp;
    logic fire;
    redirect            = rd;
    redirect_target     = tgt;
    bus.ID_ready        = idr;
    bus.imem_req_ready  = rqr;
    resp                = ren && (pend.size() > 0);
    bus.imem_resp_valid = resp;
    bus.imem_resp_data  = resp ? instr_of(pend[0]) : 32'h0;
    #1;
    s_req_valid = bus.imem_req_valid;
    s_pcnext    = PCNext;
    s_id_valid  = bus.ID_valid;
    s_id_pc     = bus.ID_pc;
    s_id_instr  = bus.ID_instr;
    fire        = s_req_valid && rqr;
    @(posedge clk);
    @(negedge clk);
    if (resp) void'(pend.pop_front());
    if (fire) pend.push_back(PC);
    PC = s_pcnext;
  endtask

  task automatic chk_outs(input string tag, input logic rv, input logic [63:0] pn,
                          input logic iv, input logic [63:0] ipc);
    chk({tag, ".req_valid"}, {63'h0, s_req_valid}, {63'h0, rv});
    chk({tag, ".PCNext"}, s_pcnext, pn);
    chk({tag, ".ID_valid"}, {63'h0, s_id_valid}, {63'h0, iv});
    if (iv) begin
      chk({tag, ".ID_pc"}, s_id_pc, ipc);
      chk({tag, ".ID_instr"}, {32'h0, s_id_instr}, {32'h0, instr_of(ipc)});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // streaming, fill to full, one issue per pop, then sustained push+pop
    tbl[0]  = mk(1, 1, 64'h04, 0, 64'h00);
    tbl[1]  = mk(1, 1, 64'h08, 0, 64'h00);
    tbl[2]  = mk(1, 1, 64'h0C, 1, 64'h00);
    tbl[3]  = mk(1, 1, 64'h10, 1, 64'h04);
    tbl[4]  = mk(0, 1, 64'h14, 1, 64'h08);
    tbl[5]  = mk(0, 1, 64'h18, 1, 64'h08);
    tbl[6]  = mk(0, 0, 64'h18, 1, 64'h08);
    tbl[7]  = mk(0, 0, 64'h18, 1, 64'h08);
    tbl[8]  = mk(0, 0, 64'h18, 1, 64'h08);
    tbl[9]  = mk(1, 0, 64'h18, 1, 64'h08);
    tbl[10] = mk(0, 1, 64'h1C, 1, 64'h0C);
    tbl[11] = mk(0, 0, 64'h1C, 1, 64'h0C);
    tbl[12] = mk(0, 0, 64'h1C, 1, 64'h0C);
    tbl[13] = mk(1, 0, 64'h1C, 1, 64'h0C);
    tbl[14] = mk(1, 1, 64'h20, 1, 64'h10);
    tbl[15] = mk(1, 1, 64'h24, 1, 64'h14);
    tbl[16] = mk(1, 1, 64'h28, 1, 64'h18);
    tbl[17] = mk(1, 1, 64'h2C, 1, 64'h1C);
    tbl[18] = mk(1, 1, 64'h30, 1, 64'h20);
    tbl[19] = mk(1, 1, 64'h34, 1, 64'h24);
    tbl[20] = mk(0, 1, 64'h38, 1, 64'h28);

    rst                 = 1'b0;
    PC                  = 64'h0;
    redirect            = 1'b0;
    redirect_target     = 64'h0;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.ID_ready        = 1'b1;

    @(negedge clk);
    #1;
    chk("reset.ID_valid", {63'h0, bus.ID_valid}, 64'h0);
    chk("reset.req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      cyc(1'b0, 64'h0, tbl[i].id_ready, 1'b1, 1'b1);
      chk_outs($sformatf("vec%0d", i), tbl[i].req_valid, tbl[i].pcnext,
               tbl[i].id_valid, tbl[i].id_pc);
    end

    // asynchronous reset with 3 queued and 1 outstanding; late response is never sent
    #2;
    rst                 = 1'b0;
    bus.imem_resp_valid = 1'b0;
    #1;
    chk("async_rst.ID_valid", {63'h0, bus.ID_valid}, 64'h0);
    chk("async_rst.req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    pend.delete();
    PC  = 64'h10;
    rst = 1'b1;
    #1;
    chk("post_rst.ID_valid", {63'h0, bus.ID_valid}, 64'h0);

    // redirect with two requests in flight: both responses dropped
    cyc(1'b0, 64'h0,   1'b1, 1'b1, 1'b0); chk_outs("rd_a", 1'b1, 64'h14,  1'b0, 64'h0);
    cyc(1'b0, 64'h0,   1'b1, 1'b1, 1'b0); chk_outs("rd_b", 1'b1, 64'h18,  1'b0, 64'h0);
    cyc(1'b1, 64'h100, 1'b1, 1'b1, 1'b0); chk_outs("rd_c", 1'b0, 64'h100, 1'b0, 64'h0);
    cyc(1'b0, 64'h0,   1'b1, 1'b1, 1'b1); chk_outs("rd_d", 1'b1, 64'h104, 1'b0, 64'h0);
    cyc(1'b0, 64'h0,   1'b1, 1'b1, 1'b1); chk_outs("rd_e", 1'b1, 64'h108, 1'b0, 64'h0);
    cyc(1'b0, 64'h0,   1'b1, 1'b1, 1'b1); chk_outs("rd_f", 1'b0, 64'h108, 1'b0, 64'h0);
    cyc(1'b0, 64'h0,   1'b1, 1'b1, 1'b1); chk_outs("rd_g", 1'b1, 64'h10C, 1'b1, 64'h100);
    cyc(1'b0, 64'h0,   1'b1, 1'b1, 1'b1); chk_outs("rd_h", 1'b1, 64'h110, 1'b1, 64'h104);

    // redirect coinciding with a response and an ID handshake
    cyc(1'b1, 64'h200, 1'b1, 1'b1, 1'b1); chk_outs("rs_i", 1'b0, 64'h200, 1'b1, 64'h108);
    cyc(1'b0, 64'h0,   1'b1, 1'b1, 1'b1); chk_outs("rs_j", 1'b1, 64'h204, 1'b0, 64'h0);
    cyc(1'b0, 64'h0,   1'b1, 1'b1, 1'b1); chk_outs("rs_k", 1'b1, 64'h208, 1'b0, 64'h0);
    cyc(1'b0, 64'h0,   1'b1, 1'b1, 1'b1); chk_outs("rs_l", 1'b1, 64'h20C, 1'b1, 64'h200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
